// File: rtl/atm_pin_auth.sv
// PIN entry and card authentication ahead of the ATM transaction FSM.
// Collects four BCD digits, checks them against PIN, enforces retries and a timed lockout.
module atm_pin_auth #(
  parameter logic [15:0] PIN            = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          LOCK_CYCLES    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_present,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  output logic [1:0] card_input,
  output logic [2:0] digits_entered,
  output logic [1:0] tries_left,
  output logic       locked,
  output logic       timeout
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_GRANTED,
    S_SESSION,
    S_DENIED,
    S_LOCKED
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [15:0]        buffer;
  logic [2:0]         count;
  logic [1:0]         tries;
  logic [TMR_W-1:0]   idle_tmr;
  logic [LCK_W-1:0]   lock_cnt;
  logic               timeout_q;

  logic               entry_stay;
  logic               digit_ok;
  logic               tmr_fire;
  logic               entry_fire;
  logic               pin_match;
  logic               lock_done;
  logic [1:0]         tries_dec;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  // Lock counter parks at its terminal value so a card left in keeps the unit locked.
  function automatic logic [LCK_W-1:0] lock_sat_inc(input logic [LCK_W-1:0] v);
    if (v == LCK_W'(LOCK_CYCLES - 1)) return v;
    return v + 1'b1;
  endfunction

  assign digit_ok   = digit_valid && !clear && !enter && is_bcd(digit) && (count < 3'd4);
  assign tmr_fire   = (idle_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  assign entry_stay = (state == S_ENTRY) && (next_state == S_ENTRY);
  assign entry_fire = entry_stay && !clear && !digit_ok && tmr_fire;
  assign pin_match  = (buffer == PIN);
  assign lock_done  = (lock_cnt == LCK_W'(LOCK_CYCLES - 1));
  assign tries_dec  = tries - 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (card_present) next_state = S_ENTRY;
      S_ENTRY: begin
        if (!card_present)                        next_state = S_IDLE;
        else if (!clear && enter && count == 3'd4) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (!card_present)          next_state = S_IDLE;
        else if (pin_match)         next_state = S_GRANTED;
        else if (tries_dec == 2'd0) next_state = S_LOCKED;
        else                        next_state = S_DENIED;
      end
      S_GRANTED: next_state = card_present ? S_SESSION : S_IDLE;
      S_SESSION: if (!card_present) next_state = S_IDLE;
      S_DENIED:  next_state = card_present ? S_ENTRY : S_IDLE;
      // Card removal alone does not release the lock; the hold time must also expire.
      S_LOCKED:  if (lock_done && !card_present) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    card_input = 2'b00;
    case (state)
      S_GRANTED:         card_input = 2'b10;
      S_DENIED, S_LOCKED: card_input = 2'b01;
      default:           card_input = 2'b00;
    endcase
    locked         = (state == S_LOCKED);
    digits_entered = count;
    tries_left     = tries;
    timeout        = timeout_q;
  end

  // The buffer survives only while collecting digits or handing them to CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= 16'h0000;
      count  <= 3'd0;
    end else if (entry_stay) begin
      if (clear || entry_fire) begin
        buffer <= 16'h0000;
        count  <= 3'd0;
      end else if (digit_ok) begin
        buffer <= {buffer[11:0], digit};
        count  <= count + 3'd1;
      end
    end else if (!((state == S_ENTRY) && (next_state == S_CHECK))) begin
      buffer <= 16'h0000;
      count  <= 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tries <= 2'(MAX_TRIES);
    end else if (next_state == S_IDLE) begin
      tries <= 2'(MAX_TRIES);
    end else if ((state == S_CHECK) &&
                 ((next_state == S_DENIED) || (next_state == S_LOCKED))) begin
      tries <= tries_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_tmr  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= entry_fire;
      if (!entry_stay || clear || digit_ok || tmr_fire) idle_tmr <= '0;
      else                                              idle_tmr <= idle_tmr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    lock_cnt <= '0;
    else if (state != S_LOCKED) lock_cnt <= '0;
    else                        lock_cnt <= lock_sat_inc(lock_cnt);
  end

endmodule

// File: tb/tb_atm_pin_auth.sv
// Bench for atm_pin_auth: queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_atm_pin_auth;

  localparam int MAX_T   = 3;
  localparam int TMO     = 1000;
  localparam int LOCK    = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       card_present = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] card_input;
  logic [2:0] digits_entered;
  logic [1:0] tries_left;
  logic       locked;
  logic       timeout;

  int errs = 0;
  int chks = 0;

  atm_pin_auth #(
    .PIN(16'h1234), .MAX_TRIES(MAX_T), .TIMEOUT_CYCLES(TMO), .LOCK_CYCLES(LOCK)
  ) dut (
    .clk(clk), .rst(rst), .card_present(card_present), .digit_valid(digit_valid),
    .digit(digit), .enter(enter), .clear(clear), .card_input(card_input),
    .digits_entered(digits_entered), .tries_left(tries_left), .locked(locked),
    .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_GRANTED = 3,
                 M_SESSION = 4, M_DENIED = 5, M_LOCKED = 6;
  int m_phase = M_IDLE;
  int q[$];
  int m_tries = MAX_T;
  int m_idle = 0;
  int m_lock = 0;
  bit m_to = 1'b0;
  int pin_digits[4] = '{1, 2, 3, 4};

  function automatic bit q_is_pin();
    if (q.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (q[i] != pin_digits[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic go_idle();
    q.delete();
    m_tries = MAX_T;
    m_phase = M_IDLE;
  endtask

  task automatic model_reset();
    q.delete();
    m_phase = M_IDLE;
    m_tries = MAX_T;
    m_idle = 0;
    m_lock = 0;
    m_to = 1'b0;
  endtask

  task automatic model_step();
    m_to = 1'b0;
    case (m_phase)
      M_IDLE: if (card_present) begin m_phase = M_ENTRY; m_idle = 0; end
      M_ENTRY: begin
        if (!card_present) go_idle();
        else if (clear) begin q.delete(); m_idle = 0; end
        else if (enter && q.size() == 4) m_phase = M_CHECK;
        else if (!enter && digit_valid && digit <= 9 && q.size() < 4) begin
          q.push_back(int'(digit));
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TMO) begin q.delete(); m_idle = 0; m_to = 1'b1; end
        end
      end
      M_CHECK: begin
        if (!card_present) go_idle();
        else begin
          if (q_is_pin()) m_phase = M_GRANTED;
          else begin
            m_tries--;
            m_lock = 0;
            m_phase = (m_tries == 0) ? M_LOCKED : M_DENIED;
          end
          q.delete();
        end
      end
      M_GRANTED: if (!card_present) go_idle(); else m_phase = M_SESSION;
      M_SESSION: if (!card_present) go_idle();
      M_DENIED:  if (!card_present) go_idle(); else begin m_phase = M_ENTRY; m_idle = 0; end
      M_LOCKED: begin
        if (m_lock >= LOCK - 1 && !card_present) go_idle();
        else m_lock++;
      end
      default: go_idle();
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  initial forever begin
    @(negedge clk);
    check("card_input", 32'(card_input),
          (m_phase == M_GRANTED) ? 32'd2 :
          (m_phase == M_DENIED || m_phase == M_LOCKED) ? 32'd1 : 32'd0);
    check("digits_entered", 32'(digits_entered), 32'(q.size()));
    check("tries_left", 32'(tries_left), 32'(m_tries));
    check("locked", 32'(locked), 32'(m_phase == M_LOCKED));
    check("timeout", 32'(timeout), 32'(m_to));
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic press_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic keys4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  int pulses;

  initial begin
    repeat (2) tick();
    check("rst_card_input", 32'(card_input), 32'd0);
    check("rst_tries", 32'(tries_left), 32'd3);
    check("rst_count", 32'(digits_entered), 32'd0);
    rst = 1'b0;

    // Correct PIN, session, removal
    card_present = 1'b1;
    tick();
    keys4(1, 2, 3, 4);
    check("t1_count4", 32'(digits_entered), 32'd4);
    press_enter();
    check("t1_check_ci", 32'(card_input), 32'd0);
    tick();
    check("t1_granted", 32'(card_input), 32'd2);
    tick();
    check("t1_session", 32'(card_input), 32'd0);
    card_present = 1'b0;
    tick();
    check("t1_idle_tries", 32'(tries_left), 32'd3);

    // Three wrong attempts, lockout timing
    card_present = 1'b1;
    tick();
    for (int a = 0; a < 3; a++) begin
      keys4(1, 2, 3, 5);
      press_enter();
      tick();
      check("t2_denied_ci", 32'(card_input), 32'd1);
      check("t2_tries", 32'(tries_left), 32'(2 - a));
      if (a < 2) tick();
    end
    check("t2_locked", 32'(locked), 32'd1);
    key(1);
    repeat (9) tick();
    card_present = 1'b0;
    repeat (89) tick();
    check("t2_lock99", 32'(locked), 32'd1);
    check("t2_lock99_ci", 32'(card_input), 32'd1);
    tick();
    check("t2_unlocked", 32'(locked), 32'd0);
    check("t2_unlock_tries", 32'(tries_left), 32'd3);

    // Short buffer enter ignored, invalid/excess digits dropped
    card_present = 1'b1;
    tick();
    key(1); key(2); key(3);
    press_enter();
    check("t3_enter_short", 32'(digits_entered), 32'd3);
    key(4'hA);
    check("t3_digit_a", 32'(digits_entered), 32'd3);
    key(4); key(5);
    check("t3_fifth", 32'(digits_entered), 32'd4);
    press_enter();
    tick();
    check("t3_granted", 32'(card_input), 32'd2);
    card_present = 1'b0;
    repeat (2) tick();

    // One failure, then partial entry left idle until timeout
    card_present = 1'b1;
    tick();
    keys4(1, 2, 3, 5);
    press_enter();
    repeat (2) tick();
    key(1); key(2);
    pulses = 0;
    for (int i = 0; i < 1005; i++) begin
      tick();
      if (timeout === 1'b1) pulses++;
    end
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_count", 32'(digits_entered), 32'd0);
    check("t4_tries", 32'(tries_left), 32'd2);
    card_present = 1'b0;
    repeat (2) tick();

    // Strobe priority
    card_present = 1'b1;
    tick();
    keys4(1, 2, 3, 4);
    clear = 1'b1; enter = 1'b1; digit_valid = 1'b1; digit = 4'd4;
    tick();
    clear = 1'b0; enter = 1'b0; digit_valid = 1'b0;
    check("t5_clear_count", 32'(digits_entered), 32'd0);
    tick();
    check("t5_no_check", 32'(card_input), 32'd0);

    // Card pulled during CHECK
    keys4(1, 2, 3, 4);
    press_enter();
    card_present = 1'b0;
    tick();
    check("t6_pull_ci", 32'(card_input), 32'd0);
    tick();
    check("t6_pull_ci2", 32'(card_input), 32'd0);

    // Enter wins over digit, then reset inside SESSION
    card_present = 1'b1;
    tick();
    keys4(1, 2, 3, 4);
    enter = 1'b1; digit_valid = 1'b1; digit = 4'd9;
    tick();
    enter = 1'b0; digit_valid = 1'b0;
    tick();
    check("t5_enter_digit", 32'(card_input), 32'd2);
    tick();
    #2 rst = 1'b1;
    #1;
    check("t7_rst_ci", 32'(card_input), 32'd0);
    check("t7_rst_count", 32'(digits_entered), 32'd0);
    check("t7_rst_tries", 32'(tries_left), 32'd3);
    check("t7_rst_locked", 32'(locked), 32'd0);
    check("t7_rst_timeout", 32'(timeout), 32'd0);
    card_present = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/atm_pin_auth.md
# atm_pin_auth

PIN-entry and card-authentication stage sitting directly upstream of the ATM transaction FSM. It collects four BCD digits from debounced keypad pulses and compares them against a programmed PIN. It enforces a retry limit with a timed lockout, and drives the 2-bit `card_input` code (00 none, 01 invalid, 10 valid) that the transaction FSM consumes in its IDLE state.

## Interface
- `PIN`, 16'h1234: stored PIN, four BCD nibbles; first digit entered is `[15:12]`.
- `MAX_TRIES`, 3: attempts per card insertion, legal range 1..3.
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in ENTRY before the buffer is discarded.
- `LOCK_CYCLES`, 100: minimum cycles spent in LOCKED.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `card_present`  in  1  level; high while a card is inserted.
- `digit_valid`  in  1  single-cycle keypad strobe.
- `digit`  in  4  keypad value, sampled when `digit_valid`=1.
- `enter`  in  1  single-cycle strobe; submits the buffer.
- `clear`  in  1  single-cycle strobe; empties the buffer.
- `card_input`  out  2  00 none/idle, 01 invalid, 10 valid; feeds the transaction FSM.
- `digits_entered`  out  3  count of buffered digits, 0..4.
- `tries_left`  out  2  remaining attempts.
- `locked`  out  1  high in LOCKED.
- `timeout`  out  1  single-cycle pulse when the entry timeout fires.

## Operation
- States: IDLE, ENTRY, CHECK, GRANTED, SESSION, DENIED, LOCKED.
- IDLE: buffer=0, count=0, `tries_left`=MAX_TRIES. Moves to ENTRY when `card_present`=1.
- ENTRY, per-cycle priority is `clear` > `enter` > `digit_valid`. Lower-priority strobes in the same cycle are dropped.
  - `clear`: buffer and count go to 0; idle timer restarts.
  - `enter` with count=4: go to CHECK.
  - `enter` with count<4: ignored; no attempt is consumed.
  - `digit_valid` with `digit`<=9 and count<4: buffer <= {buffer[11:0], digit}; count+1; idle timer restarts.
  - `digit`>9, or count already 4: ignored; timer is not restarted.
  - Idle timer reaching TIMEOUT_CYCLES: buffer and count cleared, `timeout` pulses, timer restarts, no attempt consumed.
- CHECK lasts one cycle.
  - buffer==PIN: go to GRANTED.
  - Mismatch: `tries_left` decrements; go to LOCKED if the new value is 0, else DENIED.
- GRANTED lasts one cycle, then goes to SESSION.
- SESSION: holds until `card_present`=0, then goes to IDLE. Keypad strobes are ignored.
- DENIED lasts one cycle; buffer and count are cleared; returns to ENTRY.
- LOCKED:
  - Lock counter starts at 0 on entry; digits and enter are ignored.
  - Exits to IDLE only when the counter has reached LOCK_CYCLES-1 and `card_present`=0. Otherwise it stays.
- Card removal: `card_present`=0 in ENTRY, CHECK, GRANTED, DENIED or SESSION forces IDLE next cycle, overriding all other transitions. A pending CHECK result is discarded.
- `card_input` decode (Moore, from registered state): GRANTED → 10; DENIED and LOCKED → 01; all other states → 00. The valid code is therefore a one-cycle pulse, so the downstream FSM cannot re-enter MENU after EXIT while the card stays inserted.

## Timing
- Reset values: state IDLE, `card_input`=00, `digits_entered`=0, `tries_left`=MAX_TRIES, `locked`=0, `timeout`=0; buffer, idle timer and lock counter all 0.
- Every output is registered or decoded from registered state; there are no combinational input-to-output paths.
- `card_present` rising at edge N: ENTRY from N+1.
- `digit_valid` at edge N: `digits_entered` updates at N+1.
- `enter` at edge N with count=4: CHECK at N+1. Then either `card_input`=10 during N+2, or `card_input`=01 during N+2 with `tries_left` decremented at N+2.
- DENIED → ENTRY: new digits are accepted from N+3.
- Timeout: `timeout` is high for exactly the one cycle after the counter reaches TIMEOUT_CYCLES.
- Reset mid-operation: immediate return to reset values, regardless of state.

## Test plan
- Insert card; key 1,2,3,4; `enter`.
  - `card_input`=10 for exactly one cycle, two cycles after `enter`, then 00 in SESSION.
  - Remove card → IDLE, `tries_left`=3.
- Key 1,2,3,5 then `enter`, three times.
  - First two attempts: `card_input`=01 one cycle each; `tries_left` 2 then 1.
  - Third attempt: LOCKED, `locked`=1, `card_input` held at 01.
  - Remove card at lock cycle 10 → stays LOCKED until cycle 99, then IDLE.
- Key 1,2,3; `enter` → ignored, count stays 3. Key 4; `enter` → granted.
  - Fifth digit after four → ignored. Digit 4'hA → ignored.
- Key 1,2 then idle 1000 cycles → `timeout` pulses once, `digits_entered`=0, `tries_left` unchanged.
- Same cycle `clear`+`enter`+`digit_valid` with count=4 → buffer cleared, no CHECK.
  - Same cycle `enter`+`digit_valid` with count=4 → CHECK taken, digit dropped.
- Drop `card_present` during CHECK → IDLE, no 10/01 pulse emitted. Assert `rst` in SESSION → all outputs at reset values immediately.
